// File: rtl/ym_bus_writer.sv
// ym_bus_writer: host-side write initiator for the YM2203 (jt03) CPU port.
// Each accepted (register, value) command becomes an address write (A0=0)
// followed by a data write (A0=1). The block then polls the synchronized
// busy flag (dout[7]) before it accepts the next command.
//
// Ports:
//   clk, rst_n           system clock (shared with jt03), async active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_reg/cmd_val latched on accept
//   ym_din/ym_addr       registered data bus and A0 to jt03
//   ym_cs_n/ym_wr_n      registered chip select and write strobe to jt03
//   ym_dout              jt03 status; only bit 7 (busy) is used
//   wr_done              one-cycle pulse in the final busy-wait cycle
//   timeout_err          coincident with wr_done when busy never cleared
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a command
// A_SETUP  | cs_n low, A0=0, din=reg, before the write strobe
// A_STROBE | wr_n low for the address write
// A_HOLD   | wr_n high again, cs_n still low
// A_WAIT   | bus released between the address and data writes
// D_SETUP  | cs_n low, A0=1, din=val, before the write strobe
// D_STROBE | wr_n low for the data write
// D_HOLD   | wr_n high again, cs_n still low
// D_WAIT   | bus released, polling busy (ignored during the first BUSY_MIN cycles)
module ym_bus_writer #(
  parameter int SETUP_CYC = 2,
  parameter int WR_CYC    = 4,
  parameter int HOLD_CYC  = 1,
  parameter int ADDR_WAIT = 17,
  parameter int BUSY_MIN  = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  output logic [7:0] ym_din,
  output logic       ym_addr,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  input  logic [7:0] ym_dout,
  output logic       wr_done,
  output logic       timeout_err
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT,
    D_SETUP, D_STROBE, D_HOLD, D_WAIT
  } state_t;

  // One shared counter times every state, so it must fit the longest one.
  localparam int M1   = (SETUP_CYC > WR_CYC)   ? SETUP_CYC : WR_CYC;
  localparam int M2   = (M1 > HOLD_CYC)        ? M1 : HOLD_CYC;
  localparam int M3   = (M2 > ADDR_WAIT)       ? M2 : ADDR_WAIT;
  localparam int MAXD = (M3 > TIMEOUT)         ? M3 : TIMEOUT;
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] WR_LAST    = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] AWAIT_LAST = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] BUSY_FIRST = CW'(BUSY_MIN);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      val_q, val_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [7:0]      ym_din_q, ym_din_d;
  logic            ym_addr_q, ym_addr_d;
  logic            ym_cs_n_q, ym_cs_n_d;
  logic            ym_wr_n_q, ym_wr_n_d;
  logic            last;

  logic unused_dout;
  assign unused_dout = ^ym_dout[6:0];

  assign sync1_d = ym_dout[7];
  assign sync2_d = sync1_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    reg_d       = reg_q;
    val_d       = val_q;
    wr_done     = 1'b0;
    timeout_err = 1'b0;
    last        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          reg_d   = cmd_reg;
          val_d   = cmd_val;
          state_d = A_SETUP;
        end
      end
      A_SETUP, D_SETUP:   last = (cnt_q == SETUP_LAST);
      A_STROBE, D_STROBE: last = (cnt_q == WR_LAST);
      A_HOLD, D_HOLD:     last = (cnt_q == HOLD_LAST);
      A_WAIT:             last = (cnt_q == AWAIT_LAST);
      D_WAIT: begin
        if (cnt_q >= BUSY_FIRST && !sync2_q) begin
          wr_done = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          wr_done     = 1'b1;
          timeout_err = 1'b1;
        end
        if (wr_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (last) begin
      cnt_d = '0;
      unique case (state_q)
        A_SETUP:  state_d = A_STROBE;
        A_STROBE: state_d = A_HOLD;
        A_HOLD:   state_d = A_WAIT;
        A_WAIT:   state_d = D_SETUP;
        D_SETUP:  state_d = D_STROBE;
        D_STROBE: state_d = D_HOLD;
        D_HOLD:   state_d = D_WAIT;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Bus pins are decoded from the next state so the registered outputs line
  // up with the state they belong to, with no combinational path to the pins.
  always_comb begin
    ym_cs_n_d = 1'b1;
    ym_wr_n_d = 1'b1;
    ym_addr_d = ym_addr_q;
    ym_din_d  = ym_din_q;
    unique case (state_d)
      A_SETUP, A_STROBE, A_HOLD: begin
        ym_cs_n_d = 1'b0;
        ym_addr_d = 1'b0;
        ym_din_d  = reg_d;
        ym_wr_n_d = (state_d != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        ym_cs_n_d = 1'b0;
        ym_addr_d = 1'b1;
        ym_din_d  = val_d;
        ym_wr_n_d = (state_d != D_STROBE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reg_q     <= 8'h00;
      val_q     <= 8'h00;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      ym_din_q  <= 8'h00;
      ym_addr_q <= 1'b0;
      ym_cs_n_q <= 1'b1;
      ym_wr_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reg_q     <= reg_d;
      val_q     <= val_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ym_din_q  <= ym_din_d;
      ym_addr_q <= ym_addr_d;
      ym_cs_n_q <= ym_cs_n_d;
      ym_wr_n_q <= ym_wr_n_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign ym_din    = ym_din_q;
  assign ym_addr   = ym_addr_q;
  assign ym_cs_n   = ym_cs_n_q;
  assign ym_wr_n   = ym_wr_n_q;

endmodule

// File: tb/tb_ym_bus_writer.sv
// Bench for ym_bus_writer. A cycle-offset model derives the expected pins
// from the access timeline; literal checks pin the headline timings.
module tb_ym_bus_writer;
  localparam int S   = 2;
  localparam int W   = 4;
  localparam int H   = 1;
  localparam int AW  = 17;
  localparam int BM  = 8;
  localparam int TO  = 1024;
  localparam int P   = S + W + H;
  localparam int DW0 = 2 * P + AW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_val = 8'h00;
  logic [7:0] ym_din;
  logic       ym_addr;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic [7:0] ym_dout = 8'h00;
  logic       wr_done;
  logic       timeout_err;

  ym_bus_writer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val),
    .ym_din(ym_din), .ym_addr(ym_addr), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
    .ym_dout(ym_dout), .wr_done(wr_done), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // Model state: one command in flight, described by its start cycle.
  bit         m_busy = 1'b0;
  int         m_start = 0;
  logic [7:0] m_reg = 8'h00, m_val = 8'h00, m_din_h = 8'h00;
  logic       m_addr_h = 1'b0;
  bit         busy_hist [0:4095];
  int         acc_count = 0;
  int         done_cnt = 0;
  int         done_off = -1;
  int         done_to = 0;

  initial begin
    for (int i = 0; i < 4096; i++) busy_hist[i] = 1'b0;
    forever begin
      int c, k, t, kk;
      logic [13:0] exp_v, got_v;
      logic e_ready, e_cs, e_wr, e_addr, e_done, e_to;
      logic [7:0] e_din;
      bit b;
      @(negedge clk);
      c = cyc;
      if (c < 4096) busy_hist[c] = rst_n ? ym_dout[7] : 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0; m_addr_h = 1'b0; m_din_h = 8'h00;
      end
      e_ready = 1'b0; e_cs = 1'b1; e_wr = 1'b1; e_done = 1'b0; e_to = 1'b0;
      e_addr = m_addr_h; e_din = m_din_h;
      if (!m_busy) begin
        e_ready = 1'b1;
      end else begin
        k = c - m_start;
        if (k < P) begin
          e_addr = 1'b0; e_din = m_reg; e_cs = 1'b0;
          e_wr = !(k >= S && k < S + W);
        end else if (k < P + AW) begin
          e_addr = 1'b0; e_din = m_reg;
        end else if (k < DW0) begin
          kk = k - P - AW;
          e_addr = 1'b1; e_din = m_val; e_cs = 1'b0;
          e_wr = !(kk >= S && kk < S + W);
        end else begin
          t = k - DW0;
          e_addr = 1'b1; e_din = m_val;
          b = (c >= 2 && c - 2 < 4096) ? busy_hist[c - 2] : 1'b0;
          if (t >= BM && !b) e_done = 1'b1;
          else if (t == TO - 1) begin e_done = 1'b1; e_to = 1'b1; end
        end
      end
      exp_v = {e_ready, e_cs, e_wr, e_addr, e_din, e_done, e_to};
      got_v = {cmd_ready, ym_cs_n, ym_wr_n, ym_addr, ym_din, wr_done, timeout_err};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL pins cycle %0d: got rdy=%b cs_n=%b wr_n=%b a0=%b din=%h done=%b to=%b expected rdy=%b cs_n=%b wr_n=%b a0=%b din=%h done=%b to=%b",
                 c, cmd_ready, ym_cs_n, ym_wr_n, ym_addr, ym_din, wr_done, timeout_err,
                 e_ready, e_cs, e_wr, e_addr, e_din, e_done, e_to);
      end
      if (wr_done === 1'b1) begin
        done_cnt++;
        done_off = c - m_start;
        done_to  = int'(timeout_err);
      end
      if (m_busy && e_done) begin
        m_busy = 1'b0; m_addr_h = 1'b1; m_din_h = m_val;
      end else if (!m_busy && rst_n && cmd_valid) begin
        m_busy = 1'b1; m_start = c + 1; m_reg = cmd_reg; m_val = cmd_val;
        acc_count++;
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] v, input bit keep_valid);
    int a0;
    bit ok;
    a0 = acc_count;
    ok = 1'b0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_reg = r; cmd_val = v;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (acc_count != a0) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_wait", 0, 1);
    @(posedge clk); #2;
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_reg = ~r; cmd_val = ~v;
  endtask

  task automatic wait_k(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (cyc == m_start + n) return;
      @(negedge clk);
    end
    check("wait_k_bound", 0, 1);
  endtask

  task automatic wait_done();
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    check("done_wait", int'(ok), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s1, s2, s3;
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_cs_n", int'(ym_cs_n), 1);
    check("rst_wr_n", int'(ym_wr_n), 1);
    check("rst_din", int'(ym_din), 8'h00);
    check("rst_addr", int'(ym_addr), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset during the address strobe.
    send(8'h11, 8'h22, 1'b0);
    wait_k(3);
    check("pre_rst_wr_n", int'(ym_wr_n), 0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wr_n", int'(ym_wr_n), 1);
    check("midrst_cs_n", int'(ym_cs_n), 1);
    check("midrst_ready", int'(cmd_ready), 1);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);

    // Single write, busy already clear.
    send(8'h28, 8'hF1, 1'b0);
    wait_k(2);
    check("a_strobe_wr_n", int'(ym_wr_n), 0);
    check("a_strobe_addr", int'(ym_addr), 0);
    check("a_strobe_din", int'(ym_din), 8'h28);
    wait_k(6);
    check("a_hold_wr_n", int'(ym_wr_n), 1);
    check("a_hold_cs_n", int'(ym_cs_n), 0);
    wait_k(26);
    check("d_strobe_wr_n", int'(ym_wr_n), 0);
    check("d_strobe_addr", int'(ym_addr), 1);
    check("d_strobe_din", int'(ym_din), 8'hF1);
    wait_done();
    check("single_done_cycle", done_off, 39);
    check("single_no_timeout", done_to, 0);
    @(negedge clk);
    check("single_ready_after", int'(cmd_ready), 1);

    // Busy held until cycle 60.
    ym_dout = 8'h80;
    send(8'h30, 8'h41, 1'b0);
    wait_k(59);
    @(posedge clk); #2 ym_dout = 8'h00;
    wait_done();
    check("busy_done_cycle", done_off, 62);
    check("busy_no_timeout", done_to, 0);

    // Busy stuck high.
    ym_dout = 8'hFF;
    send(8'h24, 8'h10, 1'b0);
    wait_done();
    check("timeout_done_cycle", done_off, 1054);
    check("timeout_flag", done_to, 1);
    ym_dout = 8'h00;
    @(negedge clk);
    check("timeout_ready_after", int'(cmd_ready), 1);

    // Back-to-back with cmd_valid held high.
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send(8'h07, 8'h38, 1'b1);
    s1 = m_start;
    send(8'h08, 8'h0F, 1'b1);
    s2 = m_start;
    send(8'hA0, 8'h55, 1'b0);
    s3 = m_start;
    wait_k(26);
    check("b2b3_din", int'(ym_din), 8'h55);
    wait_done();
    check("b2b_gap1", s2 - s1, 41);
    check("b2b_gap2", s3 - s2, 41);
    check("b2b_done_count", done_cnt - d0, 3);
    check("b2b_done_cycle", done_off, 39);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
